// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial feeder for the sequence detector, one bit per clock.
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on
// o_ser_out, optionally followed by GAP idle cycles before the next word.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//   GAP        idle cycles inserted after each word (0..255)
//
// Ports
//   i_clk         rising-edge clock
//   i_reset       synchronous, active-low reset
//   i_load_data   parallel word to serialise
//   i_load_valid  i_load_data is valid
//   o_load_ready  a word can be accepted this cycle
//   o_ser_out     serial data bit (0 whenever o_ser_valid is 0)
//   o_ser_valid   o_ser_out carries a real data bit
//   o_ser_last    high during the last bit of a word
//   o_busy        high while shifting or in the inter-word gap
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP       = 0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_load_valid,
   output logic             o_load_ready,
   output logic             o_ser_out,
   output logic             o_ser_valid,
   output logic             o_ser_last,
   output logic             o_busy
);
   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
   localparam bit            HAS_GAP  = (GAP > 0);
   localparam logic [7:0]    GAP_LOAD = 8'(GAP > 0 ? GAP - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_sreg, w_sreg_nx, w_sreg_shift;
   logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nx;
   logic [7:0]       r_gap_cnt, w_gap_cnt_nx;
   logic             w_last, w_accept, w_bit;

   assign w_sreg_shift = MSB_FIRST ? (r_sreg << 1) : (r_sreg >> 1);
   assign w_bit        = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
   assign w_last       = (r_state == S_SHIFT) && (r_bit_cnt == LAST_IDX);

   // Ready depends only on registered state, so upstream can hold valid
   // without creating a combinational loop through this block.
   assign o_load_ready = (r_state == S_IDLE) || (w_last && !HAS_GAP);
   assign w_accept     = i_load_valid && o_load_ready;

   assign o_ser_valid  = (r_state == S_SHIFT);
   assign o_ser_last   = w_last;
   assign o_ser_out    = o_ser_valid && w_bit;
   assign o_busy       = (r_state != S_IDLE);

   always_comb begin
      w_state_nx   = r_state;
      w_sreg_nx    = r_sreg;
      w_bit_cnt_nx = r_bit_cnt;
      w_gap_cnt_nx = r_gap_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nx   = S_SHIFT;
               w_sreg_nx    = i_load_data;
               w_bit_cnt_nx = '0;
            end
         end
         S_SHIFT: begin
            w_sreg_nx    = w_sreg_shift;
            w_bit_cnt_nx = r_bit_cnt + 1'b1;
            if (w_last) begin
               w_bit_cnt_nx = '0;
               if (HAS_GAP) begin
                  w_state_nx   = S_GAP;
                  w_gap_cnt_nx = GAP_LOAD;
               end else if (w_accept) begin
                  // back-to-back word: reload without leaving SHIFT, no bubble
                  w_sreg_nx = i_load_data;
               end else begin
                  w_state_nx = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt == 8'd0) w_state_nx = S_IDLE;
            else w_gap_cnt_nx = r_gap_cnt - 8'd1;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state   <= S_IDLE;
         r_sreg    <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_sreg    <= w_sreg_nx;
         r_bit_cnt <= w_bit_cnt_nx;
         r_gap_cnt <= w_gap_cnt_nx;
      end
   end
endmodule
